i2s_rx: RTL and testbench

I2S_RX -- requirements
Module: i2s_rx

---
 rtl/audio_pkg.sv | 15 +
 rtl/i2s_rx_if.sv | 24 ++
 rtl/i2s_sync.sv | 27 ++
 rtl/i2s_rx.sv | 159 +++++++++++++++
 tb/tb_i2s_rx.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/audio_pkg.sv
// Shared audio definitions: default sample width, I2S receiver FSM states
// and the bclk inactivity timeout.
package audio_pkg;

  localparam int unsigned AUDIO_DATA_W   = 24;
  localparam int unsigned BCLK_TIMEOUT_W = 16;
  localparam logic [BCLK_TIMEOUT_W-1:0] BCLK_TIMEOUT = '1;

  typedef enum logic [1:0] {
    ST_HUNT,
    ST_SHIFT,
    ST_SKIP
  } rx_state_t;

endpackage

// File: rtl/i2s_rx_if.sv
// Stereo sample stream from the I2S receiver to its consumer, including
// the overrun status and its clear.
interface i2s_rx_if #(
  parameter int unsigned DATA_W = audio_pkg::AUDIO_DATA_W
);

  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] left;
  logic [DATA_W-1:0] right;
  logic              overrun;
  logic              clr_ovr;

  modport master (
    output valid, left, right, overrun,
    input  ready, clr_ovr
  );

  modport slave (
    input  valid, left, right, overrun,
    output ready, clr_ovr
  );

endinterface

// File: rtl/i2s_sync.sv
// Multi-flop synchronizer for one asynchronous input, with a registered
// copy of the synchronized level and a one-clk rising-edge pulse aligned to it.
module i2s_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise
);

  logic [STAGES-1:0] sr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr   <= '0;
      q    <= 1'b0;
      rise <= 1'b0;
    end else begin
      sr   <= STAGES'({sr, d});
      q    <= sr[STAGES-1];
      rise <= sr[STAGES-1] & ~q;
    end
  end

endmodule

// File: rtl/i2s_rx.sv
// I2S receiver: synchronizes the codec bit clock, word select and data,
// deserializes left/right words and presents complete stereo frames.
module i2s_rx
  import audio_pkg::*;
#(
  parameter int unsigned DATA_W      = AUDIO_DATA_W,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic bclk,
  input  logic lrclk,
  input  logic sdata,
  i2s_rx_if.master bus
);

  localparam int unsigned CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  logic bclk_rise, lr_s, sd_s;
  logic bclk_lvl_unused, lr_rise_unused, sd_rise_unused;

  rx_state_t                 state;
  logic [CNT_W-1:0]          bit_cnt;
  logic [DATA_W-1:0]         shreg;
  logic                      chan;
  logic                      prev_lr;
  logic                      lr_known;
  logic [BCLK_TIMEOUT_W-1:0] idle_cnt;
  logic [DATA_W-1:0]         stage_left;
  logic                      left_present;

  logic              boundary_c, timeout_c, word_done_c, frame_c;
  logic [DATA_W-1:0] shift_in_c, word_c;

  i2s_sync #(.STAGES(SYNC_STAGES)) u_sync_bclk (
    .clk (clk), .rst (rst), .d (bclk),  .q (bclk_lvl_unused), .rise (bclk_rise)
  );
  i2s_sync #(.STAGES(SYNC_STAGES)) u_sync_lrclk (
    .clk (clk), .rst (rst), .d (lrclk), .q (lr_s), .rise (lr_rise_unused)
  );
  i2s_sync #(.STAGES(SYNC_STAGES)) u_sync_sdata (
    .clk (clk), .rst (rst), .d (sdata), .q (sd_s), .rise (sd_rise_unused)
  );

  // Word completion; in a short slot the boundary bit is the word's own LSB.
  always_comb begin
    shift_in_c  = {shreg[DATA_W-2:0], sd_s};
    boundary_c  = bclk_rise && lr_known && (lr_s != prev_lr);
    timeout_c   = !bclk_rise && (idle_cnt == BCLK_TIMEOUT);
    word_done_c = 1'b0;
    word_c      = '0;
    if (state == ST_SHIFT && bclk_rise) begin
      if (boundary_c) begin
        word_done_c = 1'b1;
        word_c      = shift_in_c << (LAST_BIT - bit_cnt);
      end else if (bit_cnt == LAST_BIT) begin
        word_done_c = 1'b1;
        word_c      = shift_in_c;
      end
    end
    frame_c = word_done_c && chan && left_present;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_HUNT;
      bit_cnt      <= '0;
      shreg        <= '0;
      chan         <= 1'b0;
      prev_lr      <= 1'b0;
      lr_known     <= 1'b0;
      idle_cnt     <= '0;
      stage_left   <= '0;
      left_present <= 1'b0;
    end else begin
      if (bclk_rise) begin
        idle_cnt <= '0;
        prev_lr  <= lr_s;
        lr_known <= 1'b1;
      end else if (!timeout_c) begin
        idle_cnt <= idle_cnt + BCLK_TIMEOUT_W'(1);
      end

      // A stalled bclk means the stream restarted; resync from a fresh boundary.
      if (timeout_c) begin
        state        <= ST_HUNT;
        bit_cnt      <= '0;
        shreg        <= '0;
        lr_known     <= 1'b0;
        left_present <= 1'b0;
      end else if (bclk_rise) begin
        case (state)
          ST_HUNT: begin
            if (boundary_c) begin
              state <= ST_SHIFT;
              chan  <= lr_s;
            end
          end
          ST_SHIFT: begin
            if (boundary_c) begin
              chan    <= lr_s;
              bit_cnt <= '0;
              shreg   <= '0;
            end else if (bit_cnt == LAST_BIT) begin
              state   <= ST_SKIP;
              bit_cnt <= '0;
              shreg   <= '0;
            end else begin
              shreg   <= shift_in_c;
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
          ST_SKIP: begin
            if (boundary_c) begin
              state <= ST_SHIFT;
              chan  <= lr_s;
            end
          end
          default: state <= ST_HUNT;
        endcase
      end

      if (word_done_c) begin
        if (!chan) begin
          stage_left   <= word_c;
          left_present <= 1'b1;
        end else begin
          left_present <= 1'b0;
        end
      end
    end
  end

  // Output holding register; a frame arriving while the old one is unaccepted is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.valid   <= 1'b0;
      bus.left    <= '0;
      bus.right   <= '0;
      bus.overrun <= 1'b0;
    end else begin
      if (frame_c && (!bus.valid || bus.ready)) begin
        bus.valid <= 1'b1;
        bus.left  <= stage_left;
        bus.right <= word_c;
      end else if (bus.valid && bus.ready) begin
        bus.valid <= 1'b0;
      end

      if (frame_c && bus.valid && !bus.ready) begin
        bus.overrun <= 1'b1;
      end else if (bus.clr_ovr) begin
        bus.overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_i2s_rx.sv
// Bench for i2s_rx: an I2S transmitter model drives frames, a scoreboard
// queue holds expected stereo frames and a monitor checks each handshake.
module tb_i2s_rx;

  localparam int unsigned DW   = 24;
  localparam int          HALF = 50;

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic bclk  = 1'b0;
  logic lrclk = 1'b1;
  logic sdata = 1'b0;
  logic carry = 1'b0;

  i2s_rx_if #(.DATA_W(DW)) bus ();

  i2s_rx #(.DATA_W(DW), .SYNC_STAGES(2)) dut (
    .clk   (clk),
    .rst   (rst),
    .bclk  (bclk),
    .lrclk (lrclk),
    .sdata (sdata),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [47:0] exp_q[$];
  logic [47:0] mon_exp;

  typedef struct {
    logic [23:0] lw;
    logic [23:0] rw;
    int          dbits;
    int          slot;
    logic [23:0] el;
    logic [23:0] er;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Each accepted frame must be the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && bus.valid && bus.ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL handshake: unexpected frame %h/%h, expected none", bus.left, bus.right);
      end else begin
        mon_exp = exp_q.pop_front();
        check("frame", {bus.left, bus.right}, mon_exp);
      end
    end
  end

  task automatic send_rise(input logic lr, input logic d);
    bclk  = 1'b0;
    lrclk = lr;
    sdata = d;
    #HALF;
    bclk  = 1'b1;
    #HALF;
  endtask

  // MSB one bclk after the lrclk change; a word filling the slot spills its LSB forward.
  task automatic send_slot(input logic lr, input logic [23:0] w, input int dbits, input int slot);
    logic d;
    for (int i = 0; i < slot; i++) begin
      if (i == 0)          d = carry;
      else if (i <= dbits) d = w[dbits-i];
      else                 d = 1'b0;
      send_rise(lr, d);
    end
    carry = (dbits >= slot) ? w[dbits-slot] : 1'b0;
  endtask

  task automatic send_frame(input logic [23:0] lw, input logic [23:0] rw, input int dbits, input int slot);
    send_slot(1'b0, lw, dbits, slot);
    send_slot(1'b1, rw, dbits, slot);
  endtask

  task automatic preamble();
    carry = 1'b0;
    repeat (4) send_rise(1'b1, 1'b0);
  endtask

  task automatic do_reset();
    bclk  = 1'b0;
    lrclk = 1'b1;
    sdata = 1'b0;
    rst   = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic set_ready(input logic v);
    @(posedge clk);
    #1 bus.ready = v;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d frames still pending, expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    bus.ready   = 1'b0;
    bus.clr_ovr = 1'b0;

    vecs[0] = '{24'hA5A5A5, 24'h123456, 24, 32, 24'hA5A5A5, 24'h123456};
    vecs[1] = '{24'h000001, 24'hFFFFFF, 24, 32, 24'h000001, 24'hFFFFFF};
    vecs[2] = '{24'h008001, 24'h007FFF, 16, 16, 24'h800100, 24'h7FFF00};
    vecs[3] = '{24'h800000, 24'h7FFFFF, 24, 24, 24'h800000, 24'h7FFFFF};
    vecs[4] = '{24'hABCDEF, 24'h654321, 24, 25, 24'hABCDEF, 24'h654321};

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid",   48'(bus.valid),   48'h0);
    check("rst_left",    48'(bus.left),    48'h0);
    check("rst_right",   48'(bus.right),   48'h0);
    check("rst_overrun", 48'(bus.overrun), 48'h0);

    // Table-driven frames, ready held high
    do_reset();
    set_ready(1'b1);
    preamble();
    for (int k = 0; k < 5; k++) begin
      exp_q.push_back({vecs[k].el, vecs[k].er});
      send_frame(vecs[k].lw, vecs[k].rw, vecs[k].dbits, vecs[k].slot);
    end
    send_slot(1'b0, 24'h0, 24, 32);
    wait_drain("table");

    // Two frames with no consumer: first held, second dropped as overrun
    set_ready(1'b0);
    do_reset();
    preamble();
    send_frame(24'hA1B2C3, 24'h0F0F0F, 24, 32);
    send_frame(24'h111111, 24'h222222, 24, 32);
    repeat (10) @(negedge clk);
    check("ovr_valid", 48'(bus.valid),   48'h1);
    check("ovr_frame", {bus.left, bus.right}, {24'hA1B2C3, 24'h0F0F0F});
    check("ovr_flag",  48'(bus.overrun), 48'h1);
    @(posedge clk);
    #1 bus.clr_ovr = 1'b1;
    @(posedge clk);
    #1 bus.clr_ovr = 1'b0;
    @(negedge clk);
    check("clr_flag",  48'(bus.overrun), 48'h0);
    check("clr_valid", 48'(bus.valid),   48'h1);
    check("clr_frame", {bus.left, bus.right}, {24'hA1B2C3, 24'h0F0F0F});
    exp_q.push_back({24'hA1B2C3, 24'h0F0F0F});
    set_ready(1'b1);
    wait_drain("ovr_drain");
    @(negedge clk);
    check("ovr_valid_drop", 48'(bus.valid), 48'h0);

    // Reset in the middle of a right word
    do_reset();
    preamble();
    send_slot(1'b0, 24'h555555, 24, 32);
    for (int i = 0; i < 10; i++) send_rise(1'b1, 1'(i & 1));
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_valid", 48'(bus.valid), 48'h0);
    repeat (12) send_rise(1'b1, 1'b1);
    carry = 1'b0;
    exp_q.push_back({24'h000001, 24'hFFFFFF});
    send_frame(24'h000001, 24'hFFFFFF, 24, 32);
    wait_drain("midrst");

    // Stream joined inside a right slot
    do_reset();
    for (int i = 0; i < 10; i++) send_rise(1'b1, 1'b1);
    carry = 1'b0;
    exp_q.push_back({24'h0ABCDE, 24'h7EDCBA});
    send_frame(24'h0ABCDE, 24'h7EDCBA, 24, 32);
    wait_drain("midjoin");

    // bclk stall mid-word with a frame held at the output
    set_ready(1'b0);
    do_reset();
    preamble();
    send_frame(24'h13579B, 24'hFDB975, 24, 32);
    for (int i = 0; i < 10; i++) send_rise(1'b0, 1'b1);
    repeat (70000) @(posedge clk);
    @(negedge clk);
    check("stall_valid",   48'(bus.valid),   48'h1);
    check("stall_frame",   {bus.left, bus.right}, {24'h13579B, 24'hFDB975});
    check("stall_overrun", 48'(bus.overrun), 48'h0);
    exp_q.push_back({24'h13579B, 24'hFDB975});
    set_ready(1'b1);
    wait_drain("stall_drain");
    preamble();
    exp_q.push_back({24'hACE135, 24'h2468AC});
    send_frame(24'hACE135, 24'h2468AC, 24, 32);
    wait_drain("restart");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
